// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem read, output register plus one-entry skid buffer.
// Optional perf counters (perf_fetched, perf_squashed) are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] START_PC = ADDR_W'(32'h0000_0040)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              inst_valid,
    output logic [31:0]       inst_word,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] inst_pc_plus4
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0]       perf_fetched,
    output logic [15:0]       perf_squashed
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_word_q, out_word_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [ADDR_W-1:0] out_pc4_q, out_pc4_d;
    logic              skid_valid_q, skid_valid_d;
    logic [31:0]       skid_word_q, skid_word_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;

    logic              ack;
    logic              out_free;
    logic [ADDR_W-1:0] addr_plus4;

    assign ack        = req_q && imem_ack;
    assign out_free   = !out_valid_q || !stall;
    assign addr_plus4 = addr_q + ADDR_W'(4);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        req_d        = req_q;
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        out_pc_d     = out_pc_q;
        out_pc4_d    = out_pc4_q;
        skid_valid_d = skid_valid_q;
        skid_word_d  = skid_word_q;
        skid_pc_d    = skid_pc_q;

        if (out_free) begin
            out_valid_d = 1'b0;
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_word_d   = skid_word_q;
                out_pc_d     = skid_pc_q;
                out_pc4_d    = skid_pc_q + ADDR_W'(4);
                skid_valid_d = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (!skid_valid_q) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            S_REQ: begin
                if (ack) begin
                    pc_d = addr_plus4;
                    if (out_free && !skid_valid_q) begin
                        out_valid_d = 1'b1;
                        out_word_d  = imem_rdata;
                        out_pc_d    = addr_q;
                        out_pc4_d   = addr_plus4;
                        addr_d      = addr_plus4;
                    end else begin
                        // Decode is blocked: park the word and stop fetching until the skid drains.
                        skid_valid_d = 1'b1;
                        skid_word_d  = imem_rdata;
                        skid_pc_d    = addr_q;
                        state_d      = S_IDLE;
                        req_d        = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                if (ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (redirect_valid) begin
            pc_d         = redirect_pc & ~ADDR_W'(3);
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            addr_d       = addr_q;
            if (state_q == S_REQ && !ack) begin
                state_d = S_DRAIN;
                req_d   = 1'b1;
            end else if (state_q != S_DRAIN) begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= START_PC;
            addr_q       <= '0;
            req_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            out_pc_q     <= '0;
            out_pc4_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_word_q  <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            req_q        <= req_d;
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            out_pc_q     <= out_pc_d;
            out_pc4_q    <= out_pc4_d;
            skid_valid_q <= skid_valid_d;
            skid_word_q  <= skid_word_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = addr_q;
    assign inst_valid    = out_valid_q;
    assign inst_word     = out_word_q;
    assign inst_pc       = out_pc_q;
    assign inst_pc_plus4 = out_pc4_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [15:0] perf_squashed_q;
    logic        consume;
    logic [1:0]  squash_inc;
    logic [16:0] squash_sum;

    // Up to three squash events per cycle: dropped ack data, flushed output, flushed skid.
    assign consume    = out_valid_q && !stall;
    assign squash_inc = 2'(ack && (state_q == S_DRAIN || redirect_valid))
                      + 2'(out_valid_q && stall && redirect_valid)
                      + 2'(skid_valid_q && redirect_valid);
    assign squash_sum = {1'b0, perf_squashed_q} + 17'(squash_inc);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            if (consume && perf_fetched_q != '1)
                perf_fetched_q <= perf_fetched_q + 32'd1;
            perf_squashed_q <= squash_sum[16] ? '1 : squash_sum[15:0];
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the corner sequences, then random
// ack/stall/redirect traffic checked against an in-order instruction stream model.
module tb_fetch_stage;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack = 1'b0;
    logic [31:0]       imem_rdata;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              stall = 1'b0;
    logic              inst_valid;
    logic [31:0]       inst_word;
    logic [ADDR_W-1:0] inst_pc;
    logic [ADDR_W-1:0] inst_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       perf_fetched;
    logic [15:0]       perf_squashed;
`endif

    fetch_stage #(.ADDR_W(ADDR_W), .START_PC(32'h0000_0040)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall), .inst_valid(inst_valid), .inst_word(inst_word),
        .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
       ,.perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, ack, stl, rdr;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic rst, ack, stl, rdr, input logic [31:0] rpc,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.ack = ack; v.stl = stl; v.rdr = rdr; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        logic [31:0] exp_pc, hold_pc, hold_word, prev_addr, rpc;
        logic        hold_chk, inv_chk, prev_wait, s, r, a;
        int          n_cons;

        // Reset, streaming, 3-cycle stall with skid, delayed-ack drain, ack+redirect, alignment/wrap.
        vecs.push_back(mk(1,0,0,0,0,            0,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,            0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,            1,32'h40,0,0));
        vecs.push_back(mk(0,1,0,0,0,            1,32'h44,1,32'h40));
        vecs.push_back(mk(0,1,0,0,0,            1,32'h48,1,32'h44));
        vecs.push_back(mk(0,1,1,0,0,            0,0,1,32'h44));
        vecs.push_back(mk(0,1,1,0,0,            0,0,1,32'h44));
        vecs.push_back(mk(0,1,1,0,0,            0,0,1,32'h44));
        vecs.push_back(mk(0,1,0,0,0,            0,0,1,32'h48));
        vecs.push_back(mk(0,1,0,0,0,            1,32'h4C,0,0));
        vecs.push_back(mk(0,1,0,0,0,            1,32'h50,1,32'h4C));
        vecs.push_back(mk(0,0,0,0,0,            1,32'h50,0,0));
        vecs.push_back(mk(0,0,0,1,32'h100,      1,32'h50,0,0));
        vecs.push_back(mk(0,0,0,0,0,            1,32'h50,0,0));
        vecs.push_back(mk(0,0,0,0,0,            1,32'h50,0,0));
        vecs.push_back(mk(0,1,0,0,0,            0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,            1,32'h100,0,0));
        vecs.push_back(mk(0,1,0,0,0,            1,32'h104,1,32'h100));
        vecs.push_back(mk(0,1,0,1,32'h200,      0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            1,32'h200,0,0));
        vecs.push_back(mk(0,1,0,0,0,            1,32'h204,1,32'h200));
        vecs.push_back(mk(0,0,0,1,32'h103,      1,32'h204,0,0));
        vecs.push_back(mk(0,1,0,0,0,            0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            1,32'h100,0,0));
        vecs.push_back(mk(0,0,0,1,32'hFFFFFFFC, 1,32'h100,0,0));
        vecs.push_back(mk(0,1,0,0,0,            0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            1,32'hFFFFFFFC,0,0));
        vecs.push_back(mk(0,1,0,0,0,            1,32'h0,1,32'hFFFFFFFC));
        vecs.push_back(mk(0,1,0,0,0,            1,32'h4,1,32'h0));
        vecs.push_back(mk(0,0,1,1,32'h300,      1,32'h4,0,0));
        vecs.push_back(mk(0,1,0,0,0,            0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            1,32'h300,0,0));
        vecs.push_back(mk(0,1,0,0,0,            1,32'h304,1,32'h300));
        vecs.push_back(mk(0,1,1,0,0,            0,0,1,32'h300));
        vecs.push_back(mk(0,0,1,1,32'h400,      0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            1,32'h400,0,0));
        vecs.push_back(mk(0,1,0,0,0,            1,32'h404,1,32'h400));
        vecs.push_back(mk(1,0,0,0,0,            0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,            1,32'h40,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            reset          = vecs[i].rst;
            imem_ack       = vecs[i].ack;
            stall          = vecs[i].stl;
            redirect_valid = vecs[i].rdr;
            redirect_pc    = vecs[i].rpc;
            @(posedge clk); #1;
            check($sformatf("v%0d_req", i), imem_req, vecs[i].e_req);
            check($sformatf("v%0d_valid", i), inst_valid, vecs[i].e_valid);
            if (vecs[i].e_req || vecs[i].rst)
                check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            if (vecs[i].rst) begin
                check($sformatf("v%0d_pc", i), inst_pc, 32'h0);
                check($sformatf("v%0d_pc4", i), inst_pc_plus4, 32'h0);
                check($sformatf("v%0d_word", i), inst_word, 32'h0);
            end else if (vecs[i].e_valid) begin
                check($sformatf("v%0d_pc", i), inst_pc, vecs[i].e_pc);
                check($sformatf("v%0d_pc4", i), inst_pc_plus4, vecs[i].e_pc + 32'd4);
                check($sformatf("v%0d_word", i), inst_word, mem_word(vecs[i].e_pc));
            end
        end

        // Random traffic: decode must see an unbroken +4 stream restarting at each redirect target.
        reset = 1'b1; imem_ack = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_pc = 32'h40; n_cons = 0;
        hold_chk = 1'b0; inv_chk = 1'b0; prev_wait = 1'b0;
        hold_pc = '0; hold_word = '0; prev_addr = '0;
        for (int c = 0; c < 3000; c++) begin
            if (inv_chk) check("rnd_flush", inst_valid, 1'b0);
            if (hold_chk) begin
                check("rnd_hold_valid", inst_valid, 1'b1);
                check("rnd_hold_pc", inst_pc, hold_pc);
                check("rnd_hold_word", inst_word, hold_word);
            end
            if (prev_wait) begin
                check("rnd_req_stable", imem_req, 1'b1);
                check("rnd_addr_stable", imem_addr, prev_addr);
            end
            s   = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 19) == 0);
            a   = imem_req && ($urandom_range(0, 9) < 6);
            rpc = (c % 5 == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                               : 32'($urandom_range(0, 4095));
            if (inst_valid && !s) begin
                check("rnd_pc", inst_pc, exp_pc);
                check("rnd_word", inst_word, mem_word(exp_pc));
                check("rnd_pc4", inst_pc_plus4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                n_cons++;
            end
            if (r) exp_pc = rpc & ~32'h3;
            inv_chk   = r;
            hold_chk  = inst_valid && s && !r;
            hold_pc   = inst_pc;
            hold_word = inst_word;
            prev_wait = imem_req && !a;
            prev_addr = imem_addr;
            stall          = s;
            redirect_valid = r;
            redirect_pc    = rpc;
            imem_ack       = a;
            @(posedge clk); #1;
        end
        check("rnd_progress", 32'(n_cons > 300), 32'd1);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, 32'(n_cons));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter ADDR_W, default 32, PC and memory address width in bits.
REQ-002 Parameter START_PC, default 32'h00000040, PC loaded at reset.
REQ-003 Ports (name  direction  width  meaning):
  clk  in  1  sole clock, all state updates on rising edge
  reset  in  1  synchronous, active-high reset
  imem_req  out  1  instruction-memory read request
  imem_addr  out  ADDR_W  word-aligned read address, stable while imem_req=1
  imem_ack  in  1  read data valid this cycle, sampled only when imem_req=1
  imem_rdata  in  32  instruction word, valid with imem_ack
  redirect_valid  in  1  branch/JAL resolved taken; restart fetch
  redirect_pc  in  ADDR_W  restart target
  stall  in  1  decode cannot accept inst_word this cycle
  inst_valid  out  1  inst_word/inst_pc hold a live instruction
  inst_word  out  32  instruction word to decode (Controller instWord)
  inst_pc  out  ADDR_W  address of inst_word
  inst_pc_plus4  out  ADDR_W  inst_pc+4, for JAL link and branch base

Function
REQ-004 Decode consumes the instruction in any cycle with inst_valid=1 and stall=0; while inst_valid=1 and stall=1, inst_word, inst_pc, inst_pc_plus4 SHALL hold.
REQ-005 At most one memory request outstanding; imem_addr and imem_req SHALL be registered.
REQ-006 FSM states: IDLE (no request), REQ (request live, data kept), DRAIN (request live, data discarded).
REQ-007 IDLE->REQ when skid buffer empty and no redirect; imem_addr=pc_reg.
REQ-008 REQ with imem_ack, no redirect: data goes to output register if output free (inst_valid=0 or stall=0), else to the one-entry skid buffer; pc_reg <= imem_addr+4.
REQ-009 REQ after ack: stay REQ with imem_addr=old+4 next cycle if data went to output register; go IDLE if data went to skid.
REQ-010 When output register is consumed or empty and skid full, skid SHALL move to output register the next cycle, freeing skid.
REQ-011 Redirect has priority over stall, ack and FSM: next cycle inst_valid=0, skid empty, pc_reg=redirect_pc with bits[1:0] forced to 00.
REQ-012 Redirect in REQ without ack -> DRAIN; redirect in REQ with ack in same cycle -> ack data discarded, -> IDLE.
REQ-013 DRAIN keeps imem_req=1 and imem_addr unchanged until ack; ack data discarded, -> IDLE; redirect in DRAIN updates pc_reg only.
REQ-014 PC increment wraps modulo 2^ADDR_W; inst_pc_plus4 likewise.
REQ-015 Peak throughput one instruction per cycle when imem_ack is high in the first request cycle.

Reset
REQ-016 While reset=1 at a clock edge: state=IDLE, pc_reg=START_PC, imem_req=0, imem_addr=0, inst_valid=0, inst_word=0, inst_pc=0, inst_pc_plus4=0, skid empty.
REQ-017 Reset mid-request SHALL abandon the outstanding request without drain; memory SHALL see imem_req=0 the cycle after reset is sampled.

Configuration
REQ-018 Macro FETCH_PERF_CNT_EN defined: add outputs perf_fetched (32-bit, +1 per instruction consumed by decode) and perf_squashed (16-bit, +1 per ack data discarded or per valid output/skid entry flushed by redirect), both saturating and zeroed by reset.
REQ-019 Macro undefined: ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-020 Reset released, imem_ack=1 every cycle, stall=0 -> imem_addr 0x40,0x44,0x48 on consecutive cycles; inst_pc 0x40,0x44,0x48 on consecutive cycles, inst_valid first high two edges after reset deasserted.
REQ-021 stall=1 for 3 cycles while inst_pc=0x44 -> outputs hold 0x44, skid captures 0x48, imem_req=0; after release inst_pc 0x48 then 0x4C, no loss or duplicate.
REQ-022 Request for 0x50 with ack delayed 4 cycles, redirect_pc=0x100 in cycle 1 -> imem_addr stays 0x50 to ack, data dropped, next imem_addr=0x100, next inst_pc=0x100.
REQ-023 redirect_valid and imem_ack in same cycle -> acked word never appears; inst_valid=0 next cycle, then inst_pc=redirect target.
REQ-024 redirect_pc=0x103 -> imem_addr=0x100; redirect_pc=0xFFFFFFFC -> imem_addr 0xFFFFFFFC then 0x00000000.
REQ-025 FETCH_PERF_CNT_EN defined, run REQ-022 with one valid output flushed -> perf_squashed=2; run REQ-020 for 10 consumed instructions -> perf_fetched=10.
